// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and floor helpers for the elevator car controller
package elevator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      DOOR = 2'd2
   } state_t;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

   typedef logic [1:0] floor_t;

   // {A3,A2,A1} for a car standing at floor f
   function automatic logic [2:0] onehot_floor(input floor_t f);
      case (f)
         2'd0:    return 3'b001;
         2'd1:    return 3'b010;
         2'd2:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   // Floors lying strictly beyond f when travelling in direction d
   function automatic logic [2:0] beyond_mask(input floor_t f, input dir_t d);
      if (d == UP) begin
         case (f)
            2'd0:    return 3'b110;
            2'd1:    return 3'b100;
            default: return 3'b000;
         endcase
      end else begin
         case (f)
            2'd2:    return 3'b011;
            2'd1:    return 3'b001;
            default: return 3'b000;
         endcase
      end
   endfunction

endpackage

// File: rtl/elevator_cycle_timer.sv
// rtl/elevator_cycle_timer.sv - loadable down-counter timing both travel hops and door dwell
module cycle_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         expire
);

   logic [W-1:0] count_d;
   logic [W-1:0] count_q;

   // Load wins over counting; the counter parks at zero when idle
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (count_q != '0) begin
         count_d = count_q - W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // The final cycle of a loaded interval is the one where the count reads 1
   assign expire = (count_q == W'(1));

endmodule

// File: rtl/elevator_controller.sv
// rtl/elevator_controller.sv - three-floor car controller: call latching, scheduling, car status
module elevator_controller
   import elevator_pkg::*;
#(
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] call,
   output logic       M,
   output logic       A1,
   output logic       A2,
   output logic       A3,
   output logic       door_open,
   output logic [2:0] pending
);

   localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int TW         = $clog2(MAX_CYCLES + 1);
   localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES);
   localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES);

   state_t          state_d, state_q;
   floor_t          floor_d, floor_q;
   dir_t            dir_d, dir_q;
   logic [2:0]      pending_d, pending_q;
   logic            m_d, m_q;
   logic [2:0]      a_d, a_q;
   logic            door_d, door_q;

   logic            tmr_load;
   logic [TW-1:0]   tmr_value;
   logic            tmr_expire;
   logic [2:0]      here_mask;
   logic [2:0]      clr_mask;
   logic [2:0]      call_mask;
   floor_t          next_floor;

   cycle_timer #(
      .W (TW)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (tmr_load),
      .load_value (tmr_value),
      .expire     (tmr_expire)
   );

   // Scheduling, call latching and next-cycle car status
   always_comb begin
      state_d    = state_q;
      floor_d    = floor_q;
      dir_d      = dir_q;
      tmr_load   = 1'b0;
      tmr_value  = '0;
      clr_mask   = 3'b000;
      call_mask  = call;
      here_mask  = onehot_floor(floor_q);
      next_floor = floor_q;

      case (state_q)
         IDLE: begin
            if (|(pending_q & here_mask)) begin
               state_d   = DOOR;
               clr_mask  = here_mask;
               tmr_load  = 1'b1;
               tmr_value = DOOR_LOAD;
            end else if (|pending_q) begin
               // End floors force the direction; the middle floor reverses only
               // when nothing is waiting in the current direction
               if (floor_q == 2'd0) begin
                  dir_d = UP;
               end else if (floor_q == 2'd2) begin
                  dir_d = DOWN;
               end else if (~|(pending_q & beyond_mask(floor_q, dir_q))) begin
                  dir_d = (dir_q == UP) ? DOWN : UP;
               end
               state_d   = MOVE;
               tmr_load  = 1'b1;
               tmr_value = TRAVEL_LOAD;
            end
         end

         MOVE: begin
            if (tmr_expire) begin
               if (dir_q == UP && floor_q != 2'd2) begin
                  next_floor = floor_q + 2'd1;
               end else if (dir_q == DOWN && floor_q != 2'd0) begin
                  next_floor = floor_q - 2'd1;
               end
               floor_d = next_floor;
               if (|(pending_q & onehot_floor(next_floor))) begin
                  state_d   = DOOR;
                  clr_mask  = onehot_floor(next_floor);
                  tmr_load  = 1'b1;
                  tmr_value = DOOR_LOAD;
               end else if (|(pending_q & beyond_mask(next_floor, dir_q))) begin
                  tmr_load  = 1'b1;
                  tmr_value = TRAVEL_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         DOOR: begin
            // A call for the floor being served holds the door instead of latching
            call_mask = call & ~here_mask;
            if (|(call & here_mask)) begin
               tmr_load  = 1'b1;
               tmr_value = DOOR_LOAD;
            end else if (tmr_expire) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      pending_d = (pending_q | call_mask) & ~clr_mask;
      m_d       = (state_d == MOVE);
      door_d    = (state_d == DOOR);
      a_d       = m_d ? 3'b000 : onehot_floor(floor_d);
   end

   // State and registered car-status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         floor_q   <= 2'd0;
         dir_q     <= UP;
         pending_q <= 3'b000;
         m_q       <= 1'b0;
         a_q       <= 3'b001;
         door_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         floor_q   <= floor_d;
         dir_q     <= dir_d;
         pending_q <= pending_d;
         m_q       <= m_d;
         a_q       <= a_d;
         door_q    <= door_d;
      end
   end

   assign M            = m_q;
   assign {A3, A2, A1} = a_q;
   assign door_open    = door_q;
   assign pending      = pending_q;

endmodule

// File: tb/tb_elevator_controller.sv
// tb/tb_elevator_controller.sv - scoreboard bench for elevator_controller with a reference car model
module tb_elevator_controller;

   localparam int TRAVEL = 4;
   localparam int DWELL  = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] call = 3'b000;
   logic       M, A1, A2, A3, door_open;
   logic [2:0] pending;

   elevator_controller #(
      .TRAVEL_CYCLES (TRAVEL),
      .DOOR_CYCLES   (DWELL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .call      (call),
      .M         (M),
      .A1        (A1),
      .A2        (A2),
      .A3        (A3),
      .door_open (door_open),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   // Expected {M, A3, A2, A1, door_open, pending}
   logic [7:0] exp_q[$];
   int checks = 0;
   int passes = 0;

   // Reference car: position, remaining travel / dwell cycles, waiting floors
   int      car_floor;
   bit      going_up;
   int      travel_left;
   int      dwell_left;
   bit [2:0] waiting;

   function automatic void model_reset();
      car_floor   = 0;
      going_up    = 1'b1;
      travel_left = 0;
      dwell_left  = 0;
      waiting     = 3'b000;
   endfunction

   function automatic bit wanted_beyond(input int f, input bit up);
      for (int g = 0; g < 3; g++) begin
         if (waiting[g] && ((up && g > f) || (!up && g < f))) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic void model_step(input logic [2:0] c);
      bit [2:0] served = 3'b000;
      bit [2:0] latch  = c;
      if (dwell_left > 0) begin
         if (c[car_floor]) begin
            dwell_left = DWELL;
            latch[car_floor] = 1'b0;
         end else begin
            dwell_left = dwell_left - 1;
         end
      end else if (travel_left > 0) begin
         if (travel_left > 1) begin
            travel_left = travel_left - 1;
         end else begin
            car_floor = going_up ? car_floor + 1 : car_floor - 1;
            if (waiting[car_floor]) begin
               served[car_floor] = 1'b1;
               travel_left = 0;
               dwell_left  = DWELL;
            end else if (wanted_beyond(car_floor, going_up)) begin
               travel_left = TRAVEL;
            end else begin
               travel_left = 0;
            end
         end
      end else if (waiting != 3'b000) begin
         if (waiting[car_floor]) begin
            served[car_floor] = 1'b1;
            dwell_left = DWELL;
         end else begin
            if (car_floor == 0) going_up = 1'b1;
            else if (car_floor == 2) going_up = 1'b0;
            else if (!wanted_beyond(car_floor, going_up)) going_up = !going_up;
            travel_left = TRAVEL;
         end
      end
      waiting = (waiting | latch) & ~served;
   endfunction

   function automatic logic [7:0] model_out();
      logic       mv = (travel_left > 0);
      logic [2:0] at = mv ? 3'b000 : (3'b001 << car_floor);
      return {mv, at, (dwell_left > 0), waiting};
   endfunction

   function automatic void check_out(input string tag);
      logic [7:0] got = {M, A3, A2, A1, door_open, pending};
      logic [7:0] want = exp_q.pop_front();
      checks++;
      if (got === want) begin
         passes++;
      end else begin
         $display("FAIL %s t=%0t got M=%b A=%b door=%b pend=%b want M=%b A=%b door=%b pend=%b",
                  tag, $time, got[7], got[6:4], got[3], got[2:0],
                  want[7], want[6:4], want[3], want[2:0]);
      end
   endfunction

   // Monitor: compare after every active edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) check_out("car_status");
      end
   end

   // Monitor: reset must take effect without waiting for a clock edge
   initial begin
      forever begin
         @(negedge rst_n);
         #1;
         if (exp_q.size() > 0) check_out("async_reset");
      end
   end

   task automatic cycle(input logic [2:0] c);
      @(negedge clk);
      call = c;
      if (rst_n) model_step(c);
      exp_q.push_back(model_out());
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      model_reset();
      exp_q.push_back(model_out());
      call  = 3'b000;
      rst_n = 1'b0;
      for (int i = 1; i < n; i++) cycle(3'b000);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      call  = 3'b000;
      model_step(3'b000);
      exp_q.push_back(model_out());
   endtask

   initial begin
      logic [2:0] c;
      model_reset();
      repeat (2) cycle(3'b000);
      release_reset();

      // Quiet car stays parked at floor 1
      repeat (10) cycle(3'b000);
      // Trip to floor 3 with a pass-through floor
      cycle(3'b100);
      repeat (16) cycle(3'b000);
      // Back down to floor 1
      cycle(3'b001);
      repeat (16) cycle(3'b000);
      // Same-floor call while idle
      cycle(3'b001);
      repeat (6) cycle(3'b000);
      // Two calls at once: stop at floor 2, continue to floor 3
      cycle(3'b110);
      repeat (25) cycle(3'b000);
      cycle(3'b001);
      repeat (16) cycle(3'b000);
      // Arrive at floor 2 moving up with floors 1 and 3 waiting
      cycle(3'b010);
      cycle(3'b000);
      cycle(3'b101);
      repeat (35) cycle(3'b000);
      // Door re-pulse during the second dwell cycle
      cycle(3'b001);
      cycle(3'b000);
      cycle(3'b000);
      cycle(3'b001);
      repeat (8) cycle(3'b000);
      // Reset in the middle of a hop
      cycle(3'b100);
      repeat (3) cycle(3'b000);
      do_reset(2);
      release_reset();
      repeat (4) cycle(3'b000);

      // Random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         c = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
         cycle(c);
         if ($urandom_range(0, 599) == 0) begin
            do_reset(1 + $urandom_range(0, 2));
            release_reset();
         end
      end

      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
